// File: rtl/key_debounce_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : key_debounce_encoder                                     |
// | Description : Synchronises and debounces four raw piano keys, locks    |
// |               the highest-priority pressed key and drives the note     |
// |               decoder select/enable plus press/release strobes.        |
// | Option      : KEY_REPEAT_EN - periodic press_pulse while a key is held |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module key_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic       press_pulse,
  output logic       release_pulse
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  // The counter update that would reach the limit is the one that commits.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, HELD = 1'b1} state_t;

  logic [3:0] sync1;
  logic [3:0] ks;
  logic [3:0] stable;
  logic [1:0] lock_idx;

  state_t     state, state_d;
  logic [1:0] sel_d;
  logic       sel_en_d;
  logic       press_d;
  logic       release_d;

  // Two-flop synchroniser bringing the asynchronous key levels into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b0000;
      ks    <= 4'b0000;
    end else begin
      sync1 <= key;
      ks    <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_key
      logic [CNT_W-1:0] db_cnt;
      logic             stab;

      // Accept a new key level only after it differs for DEBOUNCE_CYCLES consecutive cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_cnt <= '0;
          stab   <= 1'b0;
        end else if (ks[i] == stab) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          stab   <= ks[i];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end

      assign stable[i] = stab;
    end
  endgenerate

  // Priority encoder: key3 wins over every lower index.
  always_comb begin
    lock_idx = 2'd0;
    if (stable[3])      lock_idx = 2'd3;
    else if (stable[2]) lock_idx = 2'd2;
    else if (stable[1]) lock_idx = 2'd1;
    else                lock_idx = 2'd0;
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt, rep_cnt_d;

  // Repeat counter register; it only moves while a key is locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt <= '0;
    else        rep_cnt <= rep_cnt_d;
  end
`endif

  // Next-state and next-output logic for the lock FSM.
  always_comb begin
    state_d   = state;
    sel_d     = sel;
    sel_en_d  = sel_en;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d = rep_cnt;
`endif
    case (state)
      IDLE: begin
        sel_en_d = 1'b0;
        if (|stable) begin
          sel_d    = lock_idx;
          sel_en_d = 1'b1;
          press_d  = 1'b1;
          state_d  = HELD;
`ifdef KEY_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end
      end
      HELD: begin
`ifdef KEY_REPEAT_EN
        if (!stable[sel]) begin
          sel_en_d  = 1'b0;
          release_d = 1'b1;
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt == REP_LAST) begin
          press_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt + 1'b1;
        end
`else
        if (!stable[sel]) begin
          sel_en_d  = 1'b0;
          release_d = 1'b1;
          state_d   = IDLE;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        sel_en_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops sel_en without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel           <= 2'd0;
      sel_en        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      sel           <= sel_d;
      sel_en        <= sel_en_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_key_debounce_encoder                                  |
// | Description : Self-checking bench for key_debounce_encoder             |
// |               (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=6).                    |
// | Option      : KEY_REPEAT_EN - selects repeat expectations              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_key_debounce_encoder;

  localparam int D = 4;
  localparam int R = 6;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'b0000;
  logic [1:0] sel;
  logic       sel_en;
  logic       press_pulse;
  logic       release_pulse;

  key_debounce_encoder #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .sel          (sel),
    .sel_en       (sel_en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int npress = 0;
  int nrel   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw key history per edge; a key level is accepted once the synchronised
  // level (raw delayed by two edges) has disagreed with the accepted level on
  // D consecutive edges, all later than the previous acceptance.
  logic [3:0] hist[$];
  int         e;
  logic [3:0] m_stable;
  int         m_last[4];
  logic       m_held;
  logic [1:0] m_sel;
  int         m_lock;
  logic       m_press, m_rel;

  function automatic logic [3:0] ks_at(input int k);
    if (k < 3) return 4'b0000;
    return hist[k-3];
  endfunction

  task automatic model_reset();
    hist.delete();
    e        = 0;
    m_stable = 4'b0000;
    for (int i = 0; i < 4; i++) m_last[i] = 0;
    m_held  = 1'b0;
    m_sel   = 2'd0;
    m_lock  = 0;
    m_press = 1'b0;
    m_rel   = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] nxt;
    logic [3:0] s;
    logic       all_diff;
    e++;
    hist.push_back(key);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (!m_held) begin
      if (m_stable != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (m_stable[i]) m_sel = 2'(i);
        m_held  = 1'b1;
        m_press = 1'b1;
        m_lock  = e;
      end
    end else if (!m_stable[m_sel]) begin
      m_held = 1'b0;
      m_rel  = 1'b1;
    end else if (REP && ((e - m_lock) % R == 0)) begin
      m_press = 1'b1;
    end
    nxt = m_stable;
    for (int i = 0; i < 4; i++) begin
      if (e - D + 1 > m_last[i]) begin
        all_diff = 1'b1;
        for (int k = e - D + 1; k <= e; k++) begin
          s = ks_at(k);
          if (s[i] == m_stable[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          nxt[i]    = ~m_stable[i];
          m_last[i] = e;
        end
      end
    end
    m_stable = nxt;
  endtask

  // One clock edge: advance the model, then sample the DUT 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cyc_sel",     sel,           m_sel);
    check("cyc_sel_en",  sel_en,        m_held);
    check("cyc_press",   press_pulse,   m_press);
    check("cyc_release", release_pulse, m_rel);
    npress += int'(press_pulse);
    nrel   += int'(release_pulse);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] k;
    int         n;
    logic [1:0] sel;
    logic       en;
    int         p_norep;
    int         p_rep;
    int         rel;
  } seg_t;

  seg_t tbl[13];

  initial begin
    logic [19:0] rep_mask, exp_mask;
    int          lock_steps;

    tbl[0]  = '{4'b0000, 10, 2'd0, 1'b0, 0, 0, 0};
    tbl[1]  = '{4'b0010, 10, 2'd1, 1'b1, 1, 1, 0};
    tbl[2]  = '{4'b0000, 10, 2'd1, 1'b0, 0, 1, 1};
    tbl[3]  = '{4'b0100,  3, 2'd1, 1'b0, 0, 0, 0};
    tbl[4]  = '{4'b0000, 10, 2'd1, 1'b0, 0, 0, 0};
    tbl[5]  = '{4'b0001, 10, 2'd0, 1'b1, 1, 1, 0};
    tbl[6]  = '{4'b1001, 10, 2'd0, 1'b1, 0, 2, 0};
    tbl[7]  = '{4'b1000, 10, 2'd3, 1'b1, 1, 2, 1};
    tbl[8]  = '{4'b0000, 10, 2'd3, 1'b0, 0, 1, 1};
    tbl[9]  = '{4'b1010, 10, 2'd3, 1'b1, 1, 1, 0};
    tbl[10] = '{4'b0000, 10, 2'd3, 1'b0, 0, 1, 1};
    tbl[11] = '{4'b0110, 10, 2'd2, 1'b1, 1, 1, 0};
    tbl[12] = '{4'b0000, 10, 2'd2, 1'b0, 0, 1, 1};

    // Reset with all keys pressed: outputs stay quiet.
    model_reset();
    rst_n = 1'b0;
    key   = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rst_sel",     sel,           2'd0);
      check("rst_sel_en",  sel_en,        1'b0);
      check("rst_press",   press_pulse,   1'b0);
      check("rst_release", release_pulse, 1'b0);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 6) check("rst_lock_e6_en", sel_en, 1'b0);
      if (c == 7) begin
        check("rst_lock_e7_sel",   sel,         2'd3);
        check("rst_lock_e7_en",    sel_en,      1'b1);
        check("rst_lock_e7_press", press_pulse, 1'b1);
      end
    end

    // Asynchronous reset while HELD: sel_en must drop before any clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_sel_en", sel_en, 1'b0);
    check("async_rst_sel",    sel,    2'd0);
    model_reset();
    key = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven segments.
    for (int s = 0; s < 13; s++) begin
      key    = tbl[s].k;
      npress = 0;
      nrel   = 0;
      for (int c = 0; c < tbl[s].n; c++) step();
      check($sformatf("seg%0d_sel", s),     sel,    tbl[s].sel);
      check($sformatf("seg%0d_en", s),      sel_en, tbl[s].en);
      check($sformatf("seg%0d_press", s),   npress, REP ? tbl[s].p_rep : tbl[s].p_norep);
      check($sformatf("seg%0d_release", s), nrel,   tbl[s].rel);
    end

    // Hold key2 for 20 cycles after lock and record press_pulse offsets.
    key        = 4'b0100;
    lock_steps = 0;
    for (int c = 1; c <= 20 && lock_steps == 0; c++) begin
      step();
      if (press_pulse) lock_steps = c;
    end
    check("hold_lock_latency", lock_steps, 7);
    rep_mask = '0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (press_pulse) rep_mask[c-1] = 1'b1;
    end
    exp_mask = '0;
    if (REP) begin
      exp_mask[5]  = 1'b1;
      exp_mask[11] = 1'b1;
      exp_mask[17] = 1'b1;
    end
    check("hold_repeat_mask", rep_mask, exp_mask);
    key = 4'b0000;
    repeat (10) step();

    // Random key activity against the reference model.
    for (int s = 0; s < 80; s++) begin
      key = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) step();
    end
    key = 4'b0000;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
